// File: rtl/dsc_seq_pkg.sv
// Shared types and constants for the DSC operation sequencer.
// Optional feature macro: DSC_SEQ_PERF_EN (adds performance counters to the top).
package dsc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } seq_state_e;

    localparam int PERF_OPS_W = 32;
    localparam int PERF_CYC_W = 48;

endpackage

// File: rtl/dsc_seq_run_ctr.sv
// Saturating run-cycle counter for the DSC operation sequencer.
// A synchronous clear wins over increment; the count sticks at all-ones and never wraps.
module dsc_seq_run_ctr #(
    parameter int WXIP1 = 17
) (
    input  logic             gclk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WXIP1-1:0] count,
    output logic             at_max
);

    logic [WXIP1-1:0] count_q;
    logic [WXIP1-1:0] count_d;

    // Next count: clear to zero, otherwise step by one until all-ones is reached
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && !at_max) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with asynchronous active-low reset
    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign at_max = &count_q;

endmodule

// File: rtl/dsc_op_sequencer.sv
// Control stage for the DSC multiply core: accepts one operand set, clears the core,
// runs it until done / cycle budget / counter saturation, and presents the captured
// result to a valid/ready consumer.
// Optional feature macro: DSC_SEQ_PERF_EN (adds perf_ops and perf_cycles outputs).
module dsc_op_sequencer
    import dsc_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_INPUTS = 2,
    parameter int WXIP1      = 17
) (
    input  logic                             gclk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [WXIP1-1:0]                 cycle_limit,
    output logic                             core_rst,
    output logic                             core_en,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data,
    input  logic [WXIP1-1:0]                 core_result,
    input  logic                             core_done,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WXIP1-1:0]                 out_result,
    output logic [WXIP1-1:0]                 out_cycles,
    output logic                             out_truncated,
    output logic                             out_saturated
`ifdef DSC_SEQ_PERF_EN
    ,
    output logic [PERF_OPS_W-1:0]            perf_ops,
    output logic [PERF_CYC_W-1:0]            perf_cycles
`endif
);

    seq_state_e state_q;
    seq_state_e state_d;

    logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data_q;
    logic [WXIP1-1:0]                 lim_q;
    logic [WXIP1-1:0]                 out_result_q;
    logic [WXIP1-1:0]                 out_cycles_q;
    logic                             out_valid_q;
    logic                             out_trunc_q;
    logic                             out_sat_q;

    logic [WXIP1-1:0] count;
    logic             at_max;
    logic             lim_hit;
    logic             run_exit;
    logic             out_hs;

    dsc_seq_run_ctr #(
        .WXIP1 (WXIP1)
    ) u_run_ctr (
        .gclk   (gclk),
        .rst_n  (rst_n),
        .clear  (state_q == CLEAR),
        .inc    (state_q == RUN),
        .count  (count),
        .at_max (at_max)
    );

    // A zero budget disables the limit; a budget already passed can never match again
    assign lim_hit  = (lim_q != '0) && (count == lim_q);
    assign run_exit = (state_q == RUN) && (core_done || lim_hit || at_max);
    assign out_hs   = out_valid_q && out_ready;

    // State register
    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept, one clear cycle, run until an exit condition, hold for drain
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = CLEAR;
            CLEAR:                  state_d = RUN;
            RUN:     if (run_exit)  state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Core control outputs; in HOLD the core is frozen rather than cleared
    always_comb begin
        in_ready = 1'b0;
        core_rst = 1'b0;
        core_en  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                core_rst = 1'b1;
            end
            CLEAR:   core_rst = 1'b1;
            RUN:     core_en  = 1'b1;
            HOLD:    ;
            default: core_rst = 1'b1;
        endcase
    end

    // Operand/budget latch on accept and result capture on run exit (done > limit > saturation)
    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            core_data_q  <= '0;
            lim_q        <= '0;
            out_result_q <= '0;
            out_cycles_q <= '0;
            out_trunc_q  <= 1'b0;
            out_sat_q    <= 1'b0;
        end else begin
            if ((state_q == IDLE) && in_valid) begin
                core_data_q <= in_data;
                lim_q       <= cycle_limit;
            end
            if (run_exit) begin
                out_result_q <= core_result;
                out_cycles_q <= count;
                out_trunc_q  <= !core_done;
                out_sat_q    <= !core_done && !lim_hit && at_max;
            end
        end
    end

    // Result valid flag: set on run exit, dropped on the consumer handshake
    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
        end else if (run_exit) begin
            out_valid_q <= 1'b1;
        end else if (out_hs) begin
            out_valid_q <= 1'b0;
        end
    end

    assign core_data     = core_data_q;
    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign out_cycles    = out_cycles_q;
    assign out_truncated = out_trunc_q;
    assign out_saturated = out_sat_q;

`ifdef DSC_SEQ_PERF_EN
    logic [PERF_OPS_W-1:0] perf_ops_q;
    logic [PERF_CYC_W-1:0] perf_cyc_q;
    logic [PERF_CYC_W:0]   perf_cyc_sum;

    assign perf_cyc_sum = {1'b0, perf_cyc_q} + {{(PERF_CYC_W + 1 - WXIP1){1'b0}}, out_cycles_q};

    // Saturating operation and cycle totals, updated on each consumer handshake
    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q <= '0;
            perf_cyc_q <= '0;
        end else if (out_hs) begin
            if (!(&perf_ops_q)) begin
                perf_ops_q <= perf_ops_q + 1'b1;
            end
            perf_cyc_q <= perf_cyc_sum[PERF_CYC_W] ? {PERF_CYC_W{1'b1}} : perf_cyc_sum[PERF_CYC_W-1:0];
        end
    end

    assign perf_ops    = perf_ops_q;
    assign perf_cycles = perf_cyc_q;
`endif

endmodule
